// File: rtl/dnn_pkg.sv
// Shared constants, types and the accumulator-to-word conversion for the DNN datapath.
//   I_WIDTH    : accumulator bank index width (bank depth 2**I_WIDTH)
//   D_WIDTH    : output word width; raw accumulators are 2*D_WIDTH wide
//   FRAC_SHIFT : LSB position of the kept magnitude field inside a raw accumulator
package dnn_pkg;

  localparam int unsigned I_WIDTH    = 4;
  localparam int unsigned D_WIDTH    = 16;
  localparam int unsigned FRAC_SHIFT = 9;

  localparam int unsigned RAW_WIDTH  = 2 * D_WIDTH;
  localparam int unsigned CNT_WIDTH  = I_WIDTH + 1;
  localparam int unsigned MAG_LSB    = FRAC_SHIFT;
  localparam int unsigned MAG_MSB    = FRAC_SHIFT + D_WIDTH - 2;

  // Drain engine sequencing states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    OUT  = 3'd3,
    FIN  = 3'd4
  } drain_state_t;

  // One converted result word as presented on the output stream.
  typedef struct packed {
    logic [D_WIDTH-1:0] data;
    logic [I_WIDTH-1:0] idx;
    logic               last;
  } drain_out_t;

  // Sign bit followed by the truncated magnitude field; no rounding or saturation.
  function automatic logic [D_WIDTH-1:0] acc_to_word(input logic [RAW_WIDTH-1:0] raw);
    return {raw[RAW_WIDTH-1], raw[MAG_MSB:MAG_LSB]};
  endfunction

endpackage

// File: rtl/dnn_acc_trunc.sv
// Combinational accumulator-to-word converter shared by the writeback paths.
// Optional build macro: DEST_DRAIN_RELU_EN -- negative accumulators convert to zero.
// Without it the sign bit is passed through and the word is signed.
// Ports:
//   raw    in   RAW_WIDTH  raw accumulator value
//   word_c out  D_WIDTH    converted word (combinational)
module dnn_acc_trunc
  import dnn_pkg::*;
(
  input  logic [RAW_WIDTH-1:0] raw,
  output logic [D_WIDTH-1:0]   word_c
);

  // Bits above the magnitude field (other than the sign) and the fraction are dropped.
  logic unused_raw_bits;
  assign unused_raw_bits = ^{raw[RAW_WIDTH-2:MAG_MSB+1], raw[MAG_LSB-1:0]};

  // Conversion with optional ReLU clamp.
  always_comb begin
`ifdef DEST_DRAIN_RELU_EN
    word_c = raw[RAW_WIDTH-1] ? '0 : acc_to_word(raw);
`else
    word_c = acc_to_word(raw);
`endif
  end

endmodule

// File: rtl/dest_reg_drain.sv
// Drain engine for the destination accumulator bank: walks a contiguous (wrapping)
// index range, issues one raw read per entry, converts each accumulator to a
// D_WIDTH word and streams it out over valid/ready.
// Optional build macro: DEST_DRAIN_RELU_EN (ReLU in the converter, see dnn_acc_trunc).
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-low reset
//   start        in   begin a drain (accepted only when idle)
//   base_idx     in   first bank index
//   count        in   number of entries, 0..2**I_WIDTH
//   busy         out  drain in progress
//   done         out  one-cycle completion pulse
//   rd_idx       out  bank read index
//   rd_raw_en    out  bank read strobe; data returns the following cycle
//   rd_raw_data  in   raw accumulator from the bank
//   out_data     out  converted word
//   out_idx      out  bank index of out_data
//   out_valid    out  out_data/out_idx/out_last valid
//   out_ready    in   downstream accept
//   out_last     out  final word of the drain
module dest_reg_drain
  import dnn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [I_WIDTH-1:0]   base_idx,
  input  logic [I_WIDTH:0]     count,
  output logic                 busy,
  output logic                 done,
  output logic [I_WIDTH-1:0]   rd_idx,
  output logic                 rd_raw_en,
  input  logic [RAW_WIDTH-1:0] rd_raw_data,
  output logic [D_WIDTH-1:0]   out_data,
  output logic [I_WIDTH-1:0]   out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);

  drain_state_t         state_q, state_d;
  logic [I_WIDTH-1:0]   ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [I_WIDTH-1:0]   rd_idx_q, rd_idx_d;
  logic                 out_valid_q, out_valid_d;
  drain_out_t           out_q, out_d;
  logic [D_WIDTH-1:0]   conv_word_c;
  logic                 last_entry_c;

  // Converter on the bank return path.
  dnn_acc_trunc u_trunc (
    .raw    (rd_raw_data),
    .word_c (conv_word_c)
  );

  assign last_entry_c = (rem_q == CNT_WIDTH'(1));

  // Next-state and next-output logic; outputs are registered from the *_d values.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_idx_d    = rd_idx_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_d    = base_idx;
            rem_d    = count;
            busy_d   = 1'b1;
            rd_en_d  = 1'b1;
            rd_idx_d = base_idx;
            state_d  = RD;
          end else begin
            // Empty drain: straight to completion without touching the bank.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end
        end
      end

      RD: begin
        state_d = CAP;
      end

      CAP: begin
        out_d.data  = conv_word_c;
        out_d.idx   = ptr_q;
        out_d.last  = last_entry_c;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end

      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          out_d.last  = 1'b0;
          ptr_d       = ptr_q + I_WIDTH'(1);
          rem_d       = rem_q - CNT_WIDTH'(1);
          if (last_entry_c) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            rd_en_d  = 1'b1;
            rd_idx_d = ptr_q + I_WIDTH'(1);
            state_d  = RD;
          end
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_idx_q    <= rd_idx_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_raw_en = rd_en_q;
  assign rd_idx    = rd_idx_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_q.data;
  assign out_idx   = out_q.idx;
  assign out_last  = out_q.last;

endmodule
